// File: rtl/izh_sched_pkg.sv
// Purpose: shared word type, reset constants and FSM encoding for the Izhikevich neuron scheduler.
// Latency: none (types and constants only).
// Backpressure: none.
package izh_sched_pkg;

   typedef logic [31:0] fp32_t;

   // Resting state loaded into every neuron on reset.
   localparam fp32_t V_INIT = 32'hC282_0000;   // -65.0
   localparam fp32_t U_INIT = 32'hC150_0000;   // -13.0
   localparam fp32_t I_INIT = 32'h0000_0000;   //   0.0

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_WRITE,
      S_EMIT,
      S_DONE
   } sched_state_t;

endpackage

// File: rtl/izh_neuron_scheduler_state_file.sv
// Purpose: per-neuron v/u/I register file with a combinational read port for the scheduler.
// Latency: read is combinational; writes land on the next rising edge.
// Backpressure: none; both write ports are always accepted, write-back and current ports are independent.
module izh_state_file
   import izh_sched_pkg::*;
#(
   parameter int N_NEURON = 16,
   parameter int IDX_W    = $clog2(N_NEURON)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wb_we_i,
   input  logic [IDX_W-1:0] wb_idx_i,
   input  fp32_t            wb_v_i,
   input  fp32_t            wb_u_i,
   input  logic             cur_we_i,
   input  logic [IDX_W-1:0] cur_addr_i,
   input  fp32_t            cur_data_i,
   input  logic [IDX_W-1:0] rd_idx_i,
   output fp32_t            rd_v_o,
   output fp32_t            rd_u_o,
   output fp32_t            rd_i_o
);

   fp32_t v_q [N_NEURON];
   fp32_t u_q [N_NEURON];
   fp32_t i_q [N_NEURON];

   // Reset reloads the resting state; otherwise accept write-back and current writes independently.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int n = 0; n < N_NEURON; n++) begin
            v_q[n] <= V_INIT;
            u_q[n] <= U_INIT;
            i_q[n] <= I_INIT;
         end
      end else begin
         if (wb_we_i) begin
            v_q[wb_idx_i] <= wb_v_i;
            u_q[wb_idx_i] <= wb_u_i;
         end
         if (cur_we_i) begin
            i_q[cur_addr_i] <= cur_data_i;
         end
      end
   end

   assign rd_v_o = v_q[rd_idx_i];
   assign rd_u_o = u_q[rd_idx_i];
   assign rd_i_o = i_q[rd_idx_i];

endmodule

// File: rtl/izh_neuron_scheduler.sv
// Purpose: sweeps neurons 0..N-1 through one shared Izhikevich datapath per timestep, emits spike index events.
// Latency: busy/upd_valid one cycle after step_start; 3 cycles per neuron with a zero-wait datapath, +1 or more per spike.
// Backpressure: upd_valid held until upd_ready, spk_valid held until spk_ready; one neuron in flight at a time.
// Option: define IZH_SPIKE_COUNT_EN to add the per-step spike counter and the spk_count port.
module izh_neuron_scheduler
   import izh_sched_pkg::*;
#(
   parameter int N_NEURON = 16,
   parameter int IDX_W    = $clog2(N_NEURON)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             step_start,
   output logic             busy,
   output logic             step_done,
   input  logic             cur_we,
   input  logic [IDX_W-1:0] cur_addr,
   input  logic [31:0]      cur_data,
   output logic             upd_valid,
   input  logic             upd_ready,
   output logic [31:0]      upd_v,
   output logic [31:0]      upd_u,
   output logic [31:0]      upd_i,
   input  logic             res_valid,
   input  logic [31:0]      res_v,
   input  logic [31:0]      res_u,
   input  logic             res_spike,
`ifdef IZH_SPIKE_COUNT_EN
   output logic [IDX_W:0]   spk_count,
`endif
   output logic             spk_valid,
   input  logic             spk_ready,
   output logic [IDX_W-1:0] spk_idx
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURON - 1);

   sched_state_t     state_q;
   logic [IDX_W-1:0] idx_q;
   logic             busy_q, step_done_q, upd_valid_q, spk_valid_q;
   fp32_t            upd_v_q, upd_u_q, upd_i_q;
   logic [IDX_W-1:0] spk_idx_q;
   fp32_t            res_v_q, res_u_q;
   logic             res_spike_q;

   logic [IDX_W-1:0] idx_d;
   logic [IDX_W-1:0] rd_idx;
   fp32_t            rd_v, rd_u, rd_i;

   // Next index to be issued; the read port looks ahead so operands latch on ISSUE entry.
   assign idx_d  = idx_q + IDX_W'(1);
   assign rd_idx = (state_q == S_IDLE) ? '0 : idx_d;

   izh_state_file #(
      .N_NEURON (N_NEURON),
      .IDX_W    (IDX_W)
   ) u_state_file (
      .clk        (clk),
      .rst        (rst),
      .wb_we_i    (state_q == S_WRITE),
      .wb_idx_i   (idx_q),
      .wb_v_i     (res_v_q),
      .wb_u_i     (res_u_q),
      .cur_we_i   (cur_we),
      .cur_addr_i (cur_addr),
      .cur_data_i (cur_data),
      .rd_idx_i   (rd_idx),
      .rd_v_o     (rd_v),
      .rd_u_o     (rd_u),
      .rd_i_o     (rd_i)
   );

   // Sweep sequencer with registered handshake outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         busy_q      <= 1'b0;
         step_done_q <= 1'b0;
         upd_valid_q <= 1'b0;
         upd_v_q     <= '0;
         upd_u_q     <= '0;
         upd_i_q     <= '0;
         spk_valid_q <= 1'b0;
         spk_idx_q   <= '0;
         res_v_q     <= '0;
         res_u_q     <= '0;
         res_spike_q <= 1'b0;
      end else begin
         step_done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (step_start) begin
                  state_q     <= S_ISSUE;
                  idx_q       <= '0;
                  busy_q      <= 1'b1;
                  upd_valid_q <= 1'b1;
                  upd_v_q     <= rd_v;
                  upd_u_q     <= rd_u;
                  upd_i_q     <= rd_i;
               end
            end
            S_ISSUE: begin
               if (upd_ready) begin
                  state_q     <= S_WAIT;
                  upd_valid_q <= 1'b0;
                  upd_v_q     <= '0;
                  upd_u_q     <= '0;
                  upd_i_q     <= '0;
               end
            end
            S_WAIT: begin
               if (res_valid) begin
                  state_q     <= S_WRITE;
                  res_v_q     <= res_v;
                  res_u_q     <= res_u;
                  res_spike_q <= res_spike;
               end
            end
            S_WRITE: begin
               if (res_spike_q) begin
                  state_q     <= S_EMIT;
                  spk_valid_q <= 1'b1;
                  spk_idx_q   <= idx_q;
               end else if (idx_q == LAST_IDX) begin
                  state_q     <= S_DONE;
                  step_done_q <= 1'b1;
               end else begin
                  state_q     <= S_ISSUE;
                  idx_q       <= idx_d;
                  upd_valid_q <= 1'b1;
                  upd_v_q     <= rd_v;
                  upd_u_q     <= rd_u;
                  upd_i_q     <= rd_i;
               end
            end
            S_EMIT: begin
               if (spk_ready) begin
                  spk_valid_q <= 1'b0;
                  if (idx_q == LAST_IDX) begin
                     state_q     <= S_DONE;
                     step_done_q <= 1'b1;
                  end else begin
                     state_q     <= S_ISSUE;
                     idx_q       <= idx_d;
                     upd_valid_q <= 1'b1;
                     upd_v_q     <= rd_v;
                     upd_u_q     <= rd_u;
                     upd_i_q     <= rd_i;
                  end
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               idx_q   <= '0;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

`ifdef IZH_SPIKE_COUNT_EN
   logic [IDX_W:0] cnt_q;
   logic [IDX_W:0] spk_count_q;

   // Count accepted spike events within a sweep and publish the total when the sweep ends.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q       <= '0;
         spk_count_q <= '0;
      end else begin
         if (state_q == S_IDLE && step_start) begin
            cnt_q <= '0;
         end else if (state_q == S_EMIT && spk_ready) begin
            cnt_q <= cnt_q + (IDX_W + 1)'(1);
         end
         if (state_q == S_DONE) begin
            spk_count_q <= cnt_q;
         end
      end
   end

   assign spk_count = spk_count_q;
`endif

   assign busy      = busy_q;
   assign step_done = step_done_q;
   assign upd_valid = upd_valid_q;
   assign upd_v     = upd_v_q;
   assign upd_u     = upd_u_q;
   assign upd_i     = upd_i_q;
   assign spk_valid = spk_valid_q;
   assign spk_idx   = spk_idx_q;

endmodule

// File: tb/tb_izh_neuron_scheduler.sv
// Purpose: directed self-checking bench for izh_neuron_scheduler with a behavioural datapath/consumer.
// Latency: checks sweep length, handshake hold times and write-back visibility in the next sweep.
// Backpressure: exercises upd_ready stalls, delayed results and spk_ready stalls.
module tb_izh_neuron_scheduler;

   localparam int N = 16;
   localparam logic [31:0] V0 = 32'hC282_0000;
   localparam logic [31:0] U0 = 32'hC150_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        step_start = 1'b0;
   logic        busy, step_done;
   logic        cur_we = 1'b0;
   logic [3:0]  cur_addr = '0;
   logic [31:0] cur_data = '0;
   logic        upd_valid;
   logic        upd_ready = 1'b0;
   logic [31:0] upd_v, upd_u, upd_i;
   logic        res_valid = 1'b0;
   logic [31:0] res_v = '0, res_u = '0;
   logic        res_spike = 1'b0;
   logic        spk_valid;
   logic        spk_ready = 1'b0;
   logic [3:0]  spk_idx;
`ifdef IZH_SPIKE_COUNT_EN
   logic [4:0]  spk_count;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   // observations of the most recent sweep
   logic [31:0] obs_v [N];
   logic [31:0] obs_u [N];
   logic [31:0] obs_i [N];
   int          spk_rec_idx [N+1];
   int          spk_cyc [N+1];
   int sw_busy_cyc, sw_done_cyc, sw_issued, sw_spk_n, sw_stab_err;
   logic sw_first_busy, sw_first_uv, sw_busy_after, sw_timeout, sw_aborted;

   always #5 clk = ~clk;

   izh_neuron_scheduler #(.N_NEURON(N)) dut (
      .clk        (clk),
      .rst        (rst),
      .step_start (step_start),
      .busy       (busy),
      .step_done  (step_done),
      .cur_we     (cur_we),
      .cur_addr   (cur_addr),
      .cur_data   (cur_data),
      .upd_valid  (upd_valid),
      .upd_ready  (upd_ready),
      .upd_v      (upd_v),
      .upd_u      (upd_u),
      .upd_i      (upd_i),
      .res_valid  (res_valid),
      .res_v      (res_v),
      .res_u      (res_u),
      .res_spike  (res_spike),
`ifdef IZH_SPIKE_COUNT_EN
      .spk_count  (spk_count),
`endif
      .spk_valid  (spk_valid),
      .spk_ready  (spk_ready),
      .spk_idx    (spk_idx)
   );

   // Pulse step_start and play datapath + spike consumer cycle by cycle until step_done (or abort point).
   task automatic drive_sweep(input logic [N-1:0] mask, input int stall_k, input int rdy_lo,
                              input int res_dly, input int spk_lo, input logic [31:0] xv,
                              input logic [31:0] xu, input int abort_k);
      int  k = 0, ph = 0, wcnt = 0, rcnt = 0, spk_wait = 0;
      bit  in_issue = 0, in_spk = 0, fin = 0;
      sw_busy_cyc = 0; sw_done_cyc = -1; sw_spk_n = 0; sw_stab_err = 0;
      sw_timeout = 0; sw_aborted = 0;
      for (int n = 0; n < N; n++) begin obs_v[n] = 'x; obs_u[n] = 'x; obs_i[n] = 'x; end
      step_start = 1'b1;
      @(posedge clk); #1;
      step_start = 1'b0;
      sw_first_busy = busy;
      sw_first_uv   = upd_valid;
      for (int c = 0; c < 3000 && !fin; c++) begin
         res_valid = 1'b0;
         if (ph == 1 && k == abort_k) begin
            upd_ready = 1'b0;
            sw_aborted = 1'b1;
            break;
         end
         if (busy) sw_busy_cyc++;
         if (step_done) begin sw_done_cyc = sw_busy_cyc; fin = 1; end
         if (upd_valid && spk_valid) sw_stab_err++;
         // spike consumer
         if (spk_valid) begin
            if (!in_spk) begin
               in_spk = 1; spk_wait = 0;
               spk_rec_idx[sw_spk_n] = int'(spk_idx); spk_cyc[sw_spk_n] = 0;
            end else if (int'(spk_idx) != spk_rec_idx[sw_spk_n]) sw_stab_err++;
            spk_cyc[sw_spk_n]++;
            spk_ready = (spk_wait >= spk_lo);
            spk_wait++;
            if (spk_ready) begin in_spk = 0; if (sw_spk_n < N) sw_spk_n++; end
         end else spk_ready = 1'b0;
         // datapath
         if (upd_valid) begin
            if (k >= N) sw_stab_err++;
            else if (!in_issue) begin
               in_issue = 1; wcnt = 0;
               obs_v[k] = upd_v; obs_u[k] = upd_u; obs_i[k] = upd_i;
            end else if (upd_v !== obs_v[k] || upd_u !== obs_u[k] || upd_i !== obs_i[k]) sw_stab_err++;
            upd_ready = (k == stall_k) ? (wcnt >= rdy_lo) : 1'b1;
            wcnt++;
            if (upd_ready) begin in_issue = 0; ph = 1; rcnt = 0; end
         end else begin
            upd_ready = 1'b0;
            if (ph == 1) begin
               if (rcnt == ((k == stall_k) ? res_dly : 0)) begin
                  res_valid = 1'b1;
                  res_v = obs_v[k] ^ xv;
                  res_u = obs_u[k] ^ xu;
                  res_spike = mask[k];
                  ph = 0; k++;
               end
               rcnt++;
            end
         end
         @(posedge clk); #1;
      end
      if (!fin && !sw_aborted) sw_timeout = 1'b1;
      sw_issued = k;
      sw_busy_after = busy;
      res_valid = 1'b0; res_spike = 1'b0; upd_ready = 1'b0; spk_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_checks++; if (step_done !== 1'b0) begin n_fail++; $display("FAIL reset_step_done: got %b want 0", step_done); end
      n_checks++; if (upd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_upd_valid: got %b want 0", upd_valid); end
      n_checks++; if (spk_valid !== 1'b0) begin n_fail++; $display("FAIL reset_spk_valid: got %b want 0", spk_valid); end
      n_checks++; if (spk_idx !== 4'd0) begin n_fail++; $display("FAIL reset_spk_idx: got %0d want 0", spk_idx); end
      n_checks++; if ({upd_v, upd_u, upd_i} !== 96'd0) begin n_fail++; $display("FAIL reset_upd_ops: got %h want 0", {upd_v, upd_u, upd_i}); end
`ifdef IZH_SPIKE_COUNT_EN
      n_checks++; if (spk_count !== 5'd0) begin n_fail++; $display("FAIL reset_spk_count: got %0d want 0", spk_count); end
`endif
      rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic_sweep();
      drive_sweep('0, -1, 0, 0, 0, 32'h0, 32'h0, -1);
      n_checks++; if (sw_timeout !== 1'b0) begin n_fail++; $display("FAIL basic_timeout: step_done not seen"); end
      n_checks++; if (sw_first_busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_rise: got %b want 1", sw_first_busy); end
      n_checks++; if (sw_first_uv !== 1'b1) begin n_fail++; $display("FAIL basic_upd_valid_rise: got %b want 1", sw_first_uv); end
      n_checks++; if (sw_done_cyc != 3 * N + 1) begin n_fail++; $display("FAIL basic_sweep_len: got %0d want %0d", sw_done_cyc, 3 * N + 1); end
      n_checks++; if (sw_busy_after !== 1'b0) begin n_fail++; $display("FAIL basic_busy_fall: got %b want 0", sw_busy_after); end
      n_checks++; if (sw_issued != N) begin n_fail++; $display("FAIL basic_issued: got %0d want %0d", sw_issued, N); end
      n_checks++; if (sw_spk_n != 0) begin n_fail++; $display("FAIL basic_spikes: got %0d want 0", sw_spk_n); end
      for (int n = 0; n < N; n++) begin
         n_checks++; if (obs_v[n] !== V0) begin n_fail++; $display("FAIL basic_v[%0d]: got %h want %h", n, obs_v[n], V0); end
         n_checks++; if (obs_u[n] !== U0) begin n_fail++; $display("FAIL basic_u[%0d]: got %h want %h", n, obs_u[n], U0); end
      end
   endtask

   task automatic test_current_write();
      cur_we = 1'b1; cur_addr = 4'd3; cur_data = 32'h4120_0000;
      @(posedge clk); #1;
      cur_we = 1'b0; cur_addr = '0; cur_data = '0;
      drive_sweep('0, -1, 0, 0, 0, 32'h0, 32'h0, -1);
      n_checks++; if (sw_timeout !== 1'b0) begin n_fail++; $display("FAIL cur_timeout: step_done not seen"); end
      for (int n = 0; n < N; n++) begin
         n_checks++;
         if (obs_i[n] !== ((n == 3) ? 32'h4120_0000 : 32'h0)) begin
            n_fail++; $display("FAIL cur_i[%0d]: got %h want %h", n, obs_i[n], (n == 3) ? 32'h4120_0000 : 32'h0);
         end
      end
   endtask

   task automatic test_spike_backpressure();
      drive_sweep(16'h0020, -1, 0, 0, 4, 32'h0, 32'h0, -1);
      n_checks++; if (sw_timeout !== 1'b0) begin n_fail++; $display("FAIL spk_timeout: step_done not seen"); end
      n_checks++; if (sw_spk_n != 1) begin n_fail++; $display("FAIL spk_events: got %0d want 1", sw_spk_n); end
      n_checks++; if (spk_rec_idx[0] != 5) begin n_fail++; $display("FAIL spk_idx: got %0d want 5", spk_rec_idx[0]); end
      n_checks++; if (spk_cyc[0] != 5) begin n_fail++; $display("FAIL spk_hold: got %0d cycles want 5", spk_cyc[0]); end
      n_checks++; if (sw_stab_err != 0) begin n_fail++; $display("FAIL spk_stability: got %0d violations want 0", sw_stab_err); end
      n_checks++; if (sw_done_cyc != 3 * N + 6) begin n_fail++; $display("FAIL spk_sweep_len: got %0d want %0d", sw_done_cyc, 3 * N + 6); end
   endtask

   task automatic test_stall_writeback();
      drive_sweep('0, 2, 3, 2, 0, 32'h0000_00FF, 32'h0000_FF00, -1);
      n_checks++; if (sw_timeout !== 1'b0) begin n_fail++; $display("FAIL stall_timeout: step_done not seen"); end
      n_checks++; if (sw_stab_err != 0) begin n_fail++; $display("FAIL stall_stability: got %0d violations want 0", sw_stab_err); end
      n_checks++; if (sw_done_cyc != 3 * N + 6) begin n_fail++; $display("FAIL stall_sweep_len: got %0d want %0d", sw_done_cyc, 3 * N + 6); end
      n_checks++; if (obs_v[2] !== V0) begin n_fail++; $display("FAIL stall_v2: got %h want %h", obs_v[2], V0); end
      drive_sweep('0, -1, 0, 0, 0, 32'h0, 32'h0, -1);
      for (int n = 0; n < N; n++) begin
         n_checks++; if (obs_v[n] !== 32'hC282_00FF) begin n_fail++; $display("FAIL wb_v[%0d]: got %h want c28200ff", n, obs_v[n]); end
         n_checks++; if (obs_u[n] !== 32'hC150_FF00) begin n_fail++; $display("FAIL wb_u[%0d]: got %h want c150ff00", n, obs_u[n]); end
      end
   endtask

   task automatic test_reset_mid_sweep();
      drive_sweep('0, -1, 0, 0, 0, 32'h1111_0000, 32'h0, 7);
      n_checks++; if (sw_aborted !== 1'b1) begin n_fail++; $display("FAIL rstmid_reach_wait7: got %b want 1", sw_aborted); end
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
      n_checks++; if (upd_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_upd_valid: got %b want 0", upd_valid); end
      res_valid = 1'b1; res_v = 32'h1234_5678; res_u = 32'h9ABC_DEF0; res_spike = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      res_valid = 1'b0; res_spike = 1'b0;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_late_res_busy: got %b want 0", busy); end
      n_checks++; if (spk_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_late_res_spk: got %b want 0", spk_valid); end
      drive_sweep('0, -1, 0, 0, 0, 32'h0, 32'h0, -1);
      n_checks++; if (sw_done_cyc != 3 * N + 1) begin n_fail++; $display("FAIL rstmid_sweep_len: got %0d want %0d", sw_done_cyc, 3 * N + 1); end
      for (int n = 0; n < N; n++) begin
         n_checks++;
         if ({obs_v[n], obs_u[n], obs_i[n]} !== {V0, U0, 32'h0}) begin
            n_fail++; $display("FAIL rstmid_state[%0d]: got %h %h %h want %h %h 0", n, obs_v[n], obs_u[n], obs_i[n], V0, U0);
         end
      end
   endtask

   task automatic test_spike_count();
      drive_sweep(16'h8201, -1, 0, 0, 0, 32'h0, 32'h0, -1);
      n_checks++; if (sw_spk_n != 3) begin n_fail++; $display("FAIL cnt_events: got %0d want 3", sw_spk_n); end
      n_checks++;
      if (spk_rec_idx[0] != 0 || spk_rec_idx[1] != 9 || spk_rec_idx[2] != 15) begin
         n_fail++; $display("FAIL cnt_order: got %0d %0d %0d want 0 9 15", spk_rec_idx[0], spk_rec_idx[1], spk_rec_idx[2]);
      end
      n_checks++; if (sw_done_cyc != 3 * N + 4) begin n_fail++; $display("FAIL cnt_sweep_len: got %0d want %0d", sw_done_cyc, 3 * N + 4); end
`ifdef IZH_SPIKE_COUNT_EN
      n_checks++; if (spk_count !== 5'd3) begin n_fail++; $display("FAIL cnt_value: got %0d want 3", spk_count); end
`endif
      drive_sweep('0, -1, 0, 0, 0, 32'h0, 32'h0, -1);
      n_checks++; if (sw_spk_n != 0) begin n_fail++; $display("FAIL cnt_quiet_events: got %0d want 0", sw_spk_n); end
`ifdef IZH_SPIKE_COUNT_EN
      n_checks++; if (spk_count !== 5'd0) begin n_fail++; $display("FAIL cnt_quiet_value: got %0d want 0", spk_count); end
`endif
   endtask

   initial begin
      test_reset();
      test_basic_sweep();
      test_current_write();
      test_spike_backpressure();
      test_stall_writeback();
      test_reset_mid_sweep();
      test_spike_count();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
